// File: rtl/hex_7seg_pkg.sv
// Shared constants for the hex 7-segment scan driver: segment table, off pattern,
// digit-count limit and the per-slot scan state encoding.
package hex_7seg_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Logical patterns, 1 = lit, bit 6 = segment a; element [n] is hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

   typedef enum logic {
      S_GUARD = 1'b0,
      S_DRIVE = 1'b1
   } scan_state_e;

   function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/hex_7seg_scan_driver_if.sv
// Display bus between the value source (master) and the scan driver (slave).
interface hex_7seg_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   import hex_7seg_pkg::*;

   logic [4*N_DIGITS-1:0] i_value;
   logic [N_DIGITS-1:0]   i_dp;
   logic                  i_load;
   logic [6:0]            o_seg;
   logic                  o_dp;
   logic [N_DIGITS-1:0]   o_dig;
   logic                  o_frame;

   modport master (
      output i_value, i_dp, i_load,
      input  o_seg, o_dp, o_dig, o_frame
   );

   modport slave (
      input  i_value, i_dp, i_load,
      output o_seg, o_dp, o_dig, o_frame
   );

endinterface

// File: rtl/hex_7seg_lut.sv
// Combinational nibble to logical 7-segment pattern (1 = lit, abcdefg).
module hex_7seg_lut
   import hex_7seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Table lookup of the selected nibble.
   always_comb begin
      seg_o = seg_lookup(nib_i);
   end

endmodule

// File: rtl/hex_7seg_scan_driver.sv
// Time-multiplexed N-digit hex display driver with guard interval, double-buffered
// value, leading-zero blanking and per-digit decimal points.
module hex_7seg_scan_driver
   import hex_7seg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int CLK_DIV        = 50000,
   parameter int GUARD          = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LEADING  = 1'b1
)(
   input logic i_clk,
   input logic i_rst,
   hex_7seg_scan_driver_if.slave bus
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
   localparam scan_state_e      SLOT_START = (GUARD > 0) ? S_GUARD : S_DRIVE;
   localparam logic [6:0]          SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                DP_IDLE  = SEG_ACTIVE_LOW;
   localparam logic [N_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;
   localparam logic [N_DIGITS-1:0] DIG_ONE  = N_DIGITS'(1'b1);

   scan_state_e           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0] act_val_q, pend_val_q;
   logic [N_DIGITS-1:0]   act_dp_q, pend_dp_q;
   logic                  pend_q;
   logic                  wrap_s, wrap_q;
   logic [6:0]            seg_q;
   logic                  dp_q;
   logic [N_DIGITS-1:0]   dig_q;
   logic                  frame_q;
   logic [3:0]            nib_s;
   logic [6:0]            lut_seg_s, seg_s;
   logic                  dp_s, run_s;
   logic [N_DIGITS-1:0]   dig_s, blank_s;

   hex_7seg_lut u_lut (
      .nib_i (nib_s),
      .seg_o (lut_seg_s)
   );

   // Slot sequencing: guard phase, drive phase, then advance the digit index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CNT_ONE;
      wrap_s  = 1'b0;
      case (state_q)
         S_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = S_DRIVE;
            end else begin
               state_d = S_GUARD;
            end
         end
         S_DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = SLOT_START;
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  wrap_s = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               state_d = S_DRIVE;
            end
         end
         default: begin
            state_d = SLOT_START;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // A digit stays blank while it and every digit above it are zero without a dp.
   always_comb begin
      blank_s = '0;
      run_s   = BLANK_LEADING;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         run_s      = run_s && (act_val_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
         blank_s[k] = run_s;
      end
   end

   // Logical (active-high) pin values for the current slot.
   always_comb begin
      nib_s = 4'(act_val_q >> {idx_q, 2'b00});
      seg_s = SEG_OFF;
      dp_s  = 1'b0;
      dig_s = '0;
      if (state_q == S_DRIVE) begin
         dig_s = DIG_ONE << idx_q;
         dp_s  = act_dp_q[idx_q];
         if (blank_s[idx_q]) begin
            seg_s = SEG_OFF;
         end else begin
            seg_s = lut_seg_s;
         end
      end else begin
         seg_s = SEG_OFF;
         dp_s  = 1'b0;
         dig_s = '0;
      end
   end

   // Scan state, counters and polarity-adjusted registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= SLOT_START;
         idx_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         frame_q <= 1'b0;
         seg_q   <= SEG_IDLE;
         dp_q    <= DP_IDLE;
         dig_q   <= DIG_IDLE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_s;
         // Delayed twice so the pulse lands with the first all-off output after digit N-1.
         frame_q <= wrap_q;
         seg_q   <= SEG_ACTIVE_LOW ? ~seg_s : seg_s;
         dp_q    <= SEG_ACTIVE_LOW ? ~dp_s : dp_s;
         dig_q   <= DIG_ACTIVE_LOW ? ~dig_s : dig_s;
      end
   end

   // Pending/active double buffer; a load in the wrap cycle bypasses pending.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_q     <= 1'b0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
      end else begin
         if (bus.i_load) begin
            pend_val_q <= bus.i_value;
            pend_dp_q  <= bus.i_dp;
         end
         if (wrap_s) begin
            pend_q <= 1'b0;
            if (bus.i_load) begin
               act_val_q <= bus.i_value;
               act_dp_q  <= bus.i_dp;
            end else if (pend_q) begin
               act_val_q <= pend_val_q;
               act_dp_q  <= pend_dp_q;
            end
         end else if (bus.i_load) begin
            pend_q <= 1'b1;
         end
      end
   end

   assign bus.o_seg   = seg_q;
   assign bus.o_dp    = dp_q;
   assign bus.o_dig   = dig_q;
   assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_hex_7seg_scan_driver.sv
// Scoreboard bench: per-frame expected digit slots are queued and checked as the
// display scans them out (4 digits, 8-cycle slots, 2-cycle guard, active-low pins).
module tb_hex_7seg_scan_driver;

   localparam int N         = 4;
   localparam int CLK_DIV   = 8;
   localparam int GUARD     = 2;
   localparam int FRAME     = N * CLK_DIV;
   localparam int DRIVE_LEN = CLK_DIV - GUARD;

   typedef struct {
      logic [3:0] dig;
      logic [6:0] seg;
      logic       dp;
      int         len;
   } slot_t;

   slot_t sb[$];
   int    n_cmp = 0;
   int    n_err = 0;
   logic  clk   = 1'b0;
   logic  rst   = 1'b1;

   hex_7seg_scan_driver_if #(.N_DIGITS(N)) bus_if ();

   hex_7seg_scan_driver #(
      .N_DIGITS       (N),
      .CLK_DIV        (CLK_DIV),
      .GUARD          (GUARD),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1),
      .BLANK_LEADING  (1'b1)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
         4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
         4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
         4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  4'hF: return 7'h47;
         default: return 7'h00;
      endcase
   endfunction

   // Queue the four pin-level slots a frame of (val, dp) must produce.
   task automatic push_frame(input logic [15:0] val, input logic [3:0] dp);
      slot_t s;
      logic  run;
      logic  blank [4];
      run = 1'b1;
      for (int k = 3; k >= 0; k--) begin
         run      = run && (val[4*k +: 4] == 4'h0) && !dp[k];
         blank[k] = (k != 0) && run;
      end
      for (int k = 0; k < 4; k++) begin
         s.dig = ~(4'b0001 << k);
         s.seg = blank[k] ? 7'h7F : ~ref_seg(val[4*k +: 4]);
         s.dp  = ~dp[k];
         s.len = DRIVE_LEN;
         sb.push_back(s);
      end
   endtask

   task automatic wait_frame();
      for (int t = 0; t < 3 * FRAME; t++) begin
         @(negedge clk);
         if (bus_if.o_frame) break;
      end
      if (!bus_if.o_frame) check_eq("frame_timeout", {31'b0, bus_if.o_frame}, 32'd1);
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] d);
      @(negedge clk);
      bus_if.i_value = v;
      bus_if.i_dp    = d;
      bus_if.i_load  = 1'b1;
      @(negedge clk);
      bus_if.i_load  = 1'b0;
   endtask

   task automatic expect_next_frame(input logic [15:0] v, input logic [3:0] d);
      wait_frame();
      @(posedge clk);
      push_frame(v, d);
      wait_frame();
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_dig"}, {28'b0, bus_if.o_dig}, 32'hF);
      check_eq({tag, "_seg"}, {25'b0, bus_if.o_seg}, 32'h7F);
      check_eq({tag, "_dp"}, {31'b0, bus_if.o_dp}, 32'd1);
      check_eq({tag, "_frame"}, {31'b0, bus_if.o_frame}, 32'd0);
   endtask

   // Slot monitor: measures each drive window and the gap before it.
   initial begin : monitor
      logic       in_slot, prev_ok, stable, off_ok;
      int         len, gap, cyc, last_frame;
      logic [3:0] s_dig;
      logic [6:0] s_seg;
      logic       s_dp;
      slot_t      e;
      in_slot = 1'b0; prev_ok = 1'b0; stable = 1'b1; off_ok = 1'b1;
      len = 0; gap = 0; cyc = 0; last_frame = -1;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_slot = 1'b0; prev_ok = 1'b0; cyc = 0; last_frame = -1;
         end else begin
            cyc++;
            if (bus_if.o_frame) begin
               if (last_frame >= 0) check_eq("frame_period", cyc - last_frame, FRAME);
               last_frame = cyc;
            end
            if (bus_if.o_dig != 4'hF) begin
               if (!in_slot) begin
                  if (prev_ok && sb.size() > 0) begin
                     check_eq("gap_len", gap, GUARD);
                     check_eq("gap_off", {31'b0, off_ok}, 32'd1);
                  end
                  in_slot = 1'b1; len = 0; stable = 1'b1;
                  s_dig = bus_if.o_dig; s_seg = bus_if.o_seg; s_dp = bus_if.o_dp;
               end else if (bus_if.o_dig != s_dig || bus_if.o_seg != s_seg || bus_if.o_dp != s_dp) begin
                  stable = 1'b0;
               end
               len++;
            end else begin
               if (in_slot) begin
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     check_eq("slot_dig", {28'b0, s_dig}, {28'b0, e.dig});
                     check_eq("slot_seg", {25'b0, s_seg}, {25'b0, e.seg});
                     check_eq("slot_dp", {31'b0, s_dp}, {31'b0, e.dp});
                     check_eq("slot_len", len, e.len);
                     check_eq("slot_stable", {31'b0, stable}, 32'd1);
                  end
                  in_slot = 1'b0; prev_ok = 1'b1; gap = 0; off_ok = 1'b1;
               end
               gap++;
               if (bus_if.o_seg != 7'h7F || bus_if.o_dp != 1'b1) off_ok = 1'b0;
            end
         end
      end
   end

   initial begin
      bus_if.i_value = 16'h0000;
      bus_if.i_dp    = 4'h0;
      bus_if.i_load  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      push_frame(16'h0000, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_frame();

      load(16'h12AF, 4'h0);
      expect_next_frame(16'h12AF, 4'h0);
      load(16'h0005, 4'h0);
      expect_next_frame(16'h0005, 4'h0);
      load(16'h0005, 4'b0100);
      expect_next_frame(16'h0005, 4'b0100);
      load(16'h0000, 4'h0);
      expect_next_frame(16'h0000, 4'h0);

      // Two loads inside one frame: that frame keeps the old value, the next shows the last.
      @(posedge clk);
      push_frame(16'h0000, 4'h0);
      repeat (10) @(negedge clk);
      load(16'h1111, 4'h0);
      repeat (5) @(negedge clk);
      load(16'h2222, 4'h0);
      expect_next_frame(16'h2222, 4'h0);

      // Load captured on the wrap edge (31 edges after the frame pulse edge).
      repeat (29) @(negedge clk);
      load(16'h3C5A, 4'b0001);
      expect_next_frame(16'h3C5A, 4'b0001);

      // Reset in the middle of digit 2's drive window.
      for (int t = 0; t < 2 * FRAME; t++) begin
         @(negedge clk);
         if (bus_if.o_dig == 4'b1011) break;
      end
      if (bus_if.o_dig != 4'b1011) check_eq("dig2_timeout", {28'b0, bus_if.o_dig}, 32'hB);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_idle("midrst");
      push_frame(16'h0000, 4'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_frame();
      @(posedge clk);
      check_eq("sb_drain", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hex_7seg_scan_driver.md
# hex_7seg_scan_driver

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It latches a packed hex value, scans one digit at a time at a programmable rate with an anti-ghosting guard interval, and applies optional leading-zero blanking and per-digit decimal points. It sits between the adder datapath result and the board display pins, replacing per-digit static decoding.

## Interface
- N_DIGITS, 4, number of digits scanned (1..8)
- CLK_DIV, 50000, clock cycles per digit slot (guard + drive); must exceed GUARD
- GUARD, 4, cycles per slot with all digits disabled; 0 removes the guard phase
- SEG_ACTIVE_LOW, 1, 1: segment/dp pins drive 0 to light
- DIG_ACTIVE_LOW, 1, 1: digit-enable pins drive 0 to select
- BLANK_LEADING, 1, 1: enable leading-zero suppression
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_value  input  4*N_DIGITS  hex digits; digit k = i_value[4k+3:4k], digit 0 rightmost
- i_dp  input  N_DIGITS  decimal point request per digit
- i_load  input  1  capture i_value/i_dp into the pending buffer
- o_seg  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a
- o_dp  output  1  decimal point of the selected digit
- o_dig  output  N_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW)
- o_frame  output  1  one-cycle pulse when a full scan completes

## Operation
- Double buffer: pending registers take i_value/i_dp on any cycle with i_load=1 and set a pending flag; at frame wrap the pending data move to the active registers and the flag clears. If i_load=1 in the wrap cycle, i_value/i_dp go straight to active.
- FSM per slot: S_GUARD (GUARD cycles, o_dig all inactive, o_seg/o_dp off) -> S_DRIVE (CLK_DIV-GUARD cycles, selected digit on) -> next slot S_GUARD. GUARD=0: S_DRIVE only.
- Digit index counts 0..N_DIGITS-1, wraps to 0; the wrap cycle is the frame boundary.
- Segment map (logical, 1 = lit, abcdefg): 0 7E, 1 30, 2 6D, 3 79, 4 33, 5 5B, 6 5F, 7 70, 8 7F, 9 7B, A 77, b 1F, C 4E, d 3D, E 4F, F 47.
- Leading-zero blanking: scanning from digit N_DIGITS-1 down, a digit is blanked (segments off, still enabled during its slot) while it and every higher digit are 0 with dp clear. Digit 0 is never blanked. A set dp stops suppression at that digit.
- Polarity inversion applied last, on the registered outputs.

## Timing
- Reset (async assert, sync deassert recommended upstream): state S_GUARD (S_DRIVE if GUARD=0), index 0, slot counter 0, active/pending registers 0, pending flag 0; o_dig all inactive, o_seg and o_dp off (per polarity), o_frame 0.
- All outputs registered; output reflects state/index one cycle after the transition.
- Slot counter width $clog2(CLK_DIV); counter resets to 0 at each slot start.
- o_frame high for exactly the one cycle following the last drive cycle of digit N_DIGITS-1.
- New data visible from the first drive cycle of digit 0 in the next frame; worst-case load-to-display latency N_DIGITS*CLK_DIV+GUARD+1 cycles.
- Never two digits enabled in one cycle; guard always separates consecutive digits when GUARD>0.
- Reset mid-slot: outputs go off immediately (async), scan restarts at digit 0.

## Structure
- Package hex_7seg_pkg: 16-entry segment constant table, SEG_OFF constant, digit-count limit.
- Sub-module hex_7seg_lut: combinational nibble -> 7-bit logical segment pattern from the package table; instantiated once on the selected nibble.
- Blanking mask computed combinationally from active registers; FSM, counters, buffers in the top.

## Test plan
- N_DIGITS=4, CLK_DIV=8, GUARD=2, active-low: reset -> o_dig=4'hF, o_seg=7'h7F, o_dp=1, o_frame=0.
- Load 16'h12AF, no dp -> after first wrap, digits show F(47),A(77),2(6D),1(30) (inverted on pins), each enabled 6 cycles with 2-cycle all-off gaps; o_frame every 32 cycles.
- Load 16'h0005, BLANK_LEADING=1 -> digits 3..1 segments off, digit 0 shows 5B; with i_dp=4'b0100 digit 2 shows 7E with dp lit, digit 3 blank.
- Load 16'h0000 -> only digit 0 lights 7E.
- i_load pulses 16'h1111 then 16'h2222 mid-frame -> current frame unchanged, next frame shows 2222; load in wrap cycle shows immediately.
- Assert i_rst during digit 2 drive -> outputs off same cycle; after release scan restarts at digit 0 with value 0.
